// File: rtl/serial_adder_fsm_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
// Master drives the request and operands; slave returns status and result.
interface serial_adder_fsm_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial N-bit adder: one full-adder slice (two half-adders plus a registered
// carry) per clock, LSB first, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one bit step per clock, N steps
// DONE  | result valid, done high for this single cycle
module serial_adder_fsm #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_fsm_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  sum_sh_q, sum_sh_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic h1, c1, s, c2;

    assign h1 = a_sh_q[0] ^ b_sh_q[0];
    assign c1 = a_sh_q[0] & b_sh_q[0];
    assign s  = h1 ^ carry_q;
    assign c2 = h1 & carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    sum_sh_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                carry_d  = c1 | c2;
                sum_sh_d = {s, sum_sh_q[N-1:1]};
                a_sh_d   = {1'b0, a_sh_q[N-1:1]};
                b_sh_d   = {1'b0, b_sh_q[N-1:1]};
                cnt_d    = cnt_q + CW'(1);
                // Last bit step: publish the result directly from this slice.
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = {s, sum_sh_q[N-1:1]};
                    cout_d  = c1 | c2;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
